// File: rtl/rv_mem_pkg.sv
// Shared data-memory access definitions: funct3 size codes, MEM FSM states,
// and the size/alignment helpers used by the access unit.
package rv_mem_pkg;

  localparam logic [2:0] F3_B   = 3'd0;
  localparam logic [2:0] F3_H   = 3'd1;
  localparam logic [2:0] F3_W   = 3'd2;
  localparam logic [2:0] F3_D   = 3'd3;
  localparam logic [2:0] F3_BU  = 3'd4;
  localparam logic [2:0] F3_HU  = 3'd5;
  localparam logic [2:0] F3_WU  = 3'd6;
  localparam logic [2:0] F3_BAD = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DROP
  } state_t;

  function automatic logic [7:0] size_mask(
    input logic [2:0] f3
  );
    logic [7:0] m;
    m = 8'h00;
    case (f3)
      F3_B, F3_BU: m = 8'h01;
      F3_H, F3_HU: m = 8'h03;
      F3_W, F3_WU: m = 8'h0F;
      F3_D:        m = 8'hFF;
      default:     m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [2:0] off
  );
    logic r;
    r = 1'b0;
    case (f3)
      F3_H, F3_HU: r = off[0];
      F3_W, F3_WU: r = |off[1:0];
      F3_D:        r = |off;
      F3_BAD:      r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane shift of aligned read data plus sign/zero extension by size.
module load_extend
  import rv_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = sh;
    case (funct3)
      F3_B:  data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_H:  data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_W:  data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_BU: data = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_HU: data = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_WU: data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-bus initiator: aligns, issues a valid/ready request,
// waits for the response and returns extended load data with a done pulse.
module dmem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            memr,
  input  logic            memw,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic            flush,
  output logic            req_valid,
  input  logic            req_ready,
  output logic            req_we,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  output logic [7:0]      req_wstrb,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] dmem_data,
  output logic            done,
  output logic            stall,
  output logic            misalign_err,
  output logic            bus_err
);

  state_t          state;
  state_t          nxt;
  logic            access;
  logic            mis;
  logic            tmo;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic [7:0]      strb_q;
  logic [15:0]     cnt;
  logic            done_q;
  logic            mis_q;
  logic            bus_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] ext;

  assign access = in_valid & (memr | memw) & ~flush;
  assign mis    = misaligned(funct3, addr[2:0]);
  assign tmo    = (cnt == 16'(RESP_TIMEOUT - 1));

  load_extend #(
    .XLEN(XLEN)
  ) u_ext (
    .rdata (resp_rdata),
    .funct3(f3_q),
    .off   (addr_q[2:0]),
    .data  (ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (access) nxt = mis ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (flush && req_ready) nxt = S_DROP;
        else if (flush)         nxt = S_IDLE;
        else if (req_ready)     nxt = S_WAIT;
      end
      S_WAIT: begin
        // a response landing with the flush is consumed here
        if (flush)           nxt = (resp_valid || tmo) ? S_IDLE : S_DROP;
        else if (resp_valid) nxt = S_DONE;
        else if (tmo)        nxt = S_DONE;
      end
      S_DROP: begin
        if (resp_valid || tmo) nxt = S_IDLE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    stall     = 1'b0;
    unique case (state)
      S_IDLE:  stall = access;
      S_REQ: begin
        req_valid = 1'b1;
        stall     = 1'b1;
      end
      S_WAIT:  stall = 1'b1;
      S_DROP:  stall = 1'b1;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'd0;
      strb_q  <= 8'h00;
    end else if (state == S_IDLE && access && !mis) begin
      we_q    <= memw & ~memr;
      addr_q  <= addr;
      wdata_q <= store_data << {addr[2:0], 3'b000};
      f3_q    <= funct3;
      strb_q  <= (memw & ~memr) ?
                 8'(size_mask(funct3) << addr[2:0]) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (state == S_REQ) begin
      cnt <= 16'd0;
    end else if (state == S_WAIT || state == S_DROP) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      bus_q  <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= (nxt == S_DONE);
      mis_q  <= (state == S_IDLE) && access && mis;
      bus_q  <= (state == S_WAIT) && !flush &&
                !resp_valid && tmo;
      if (nxt == S_DONE) begin
        data_q <= (state == S_WAIT && resp_valid && !we_q) ?
                  ext : '0;
      end
    end
  end

  assign req_we       = we_q;
  assign req_addr     = {addr_q[XLEN-1:3], 3'b000};
  assign req_wdata    = wdata_q;
  assign req_wstrb    = strb_q;
  assign dmem_data    = data_q;
  assign done         = done_q;
  assign misalign_err = mis_q;
  assign bus_err      = bus_q;

endmodule
